// File: rtl/l1a_hdr_writer_pkg.sv
// l1a_hdr_writer_pkg
// Shared DMB control definitions for the L1A header writer.
// - HDR_MARK_B4 / HDR_MARK_B5 : marker bytes that open and close a header
// - hdr_state_e               : header writer state encodings
// - pend_entry_t              : 26-bit pending-queue entry {alct, cfeb, event number}
// - is_wr_state()             : true for any state that presents a header word
package l1a_hdr_writer_pkg;

    localparam logic [7:0] HDR_MARK_B4 = 8'hB4;
    localparam logic [7:0] HDR_MARK_B5 = 8'hB5;
    localparam int         EVT_NUM_W   = 24;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_B4  = 3'd1,
        ST_WR_L1L = 3'd2,
        ST_WR_L1H = 3'd3,
        ST_WR_B5  = 3'd4
    } hdr_state_e;

    typedef struct packed {
        logic                 alct_tmb_act;
        logic                 cfeb_act;
        logic [EVT_NUM_W-1:0] evt_num;
    } pend_entry_t;

    function automatic logic is_wr_state(input hdr_state_e s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/l1a_hdr_writer_pend_fifo.sv
// l1a_pend_fifo
// Synchronous first-word fall-through queue holding events that still need a
// header written. The head entry is visible on pop_data whenever empty is low.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   push, push_data   : enqueue request; ignored while full
//   pop               : dequeue the head entry; ignored while empty
//   pop_data          : current head entry
//   empty, full       : occupancy flags
//   count             : registered occupancy (0..DEPTH)
module l1a_pend_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 26
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    // DEPTH is a power of two, so "full" is exactly the top count bit set.
    localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    // Pointers wrap naturally because the depth is a power of two.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_ok ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; emptiness is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/l1a_hdr_writer.sv
// l1a_hdr_writer
// Numbers every L1A trigger, queues {ALCT, CFEB, event number}, and writes a
// four-word header (B4 marker, number low, number high, B5 trailer) for each
// queued event into a downstream FIFO, stalling while that FIFO is full.
// Ports:
//   CLK, RST            : clock, asynchronous active-high reset
//   L1A                 : one-cycle trigger pulse
//   L1A_CNT_RST         : synchronous event counter clear
//   ALCT_TMB_ACT, CFEB_ACT : activity flags captured with L1A
//   FIFO_FULL           : downstream header FIFO full
//   WR_ENA              : header FIFO write strobe (combinational)
//   DOUT, LAST_WD       : registered header word and last-word marker
//   PEND                : queued, unwritten headers
//   OVFL                : sticky pending-queue overflow
//   BUSY                : any header pending or in progress
module l1a_hdr_writer #(
    parameter int PEND_DEPTH = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          L1A,
    input  logic                          L1A_CNT_RST,
    input  logic                          ALCT_TMB_ACT,
    input  logic                          CFEB_ACT,
    input  logic                          FIFO_FULL,
    output logic                          WR_ENA,
    output logic [15:0]                   DOUT,
    output logic                          LAST_WD,
    output logic [$clog2(PEND_DEPTH):0]   PEND,
    output logic                          OVFL,
    output logic                          BUSY
);

    import l1a_hdr_writer_pkg::*;

    logic [EVT_NUM_W-1:0]          cnt_q, cnt_d;
    logic [EVT_NUM_W-1:0]          evt_num;
    pend_entry_t                   push_entry;
    pend_entry_t                   cur_q, cur_d;
    hdr_state_e                    state_q, state_d;
    logic                          fifo_pop;
    logic [$bits(pend_entry_t)-1:0] pop_data;
    logic                          fifo_empty, fifo_full;
    logic [$clog2(PEND_DEPTH):0]   fifo_count;
    logic [15:0]                   dout_q, dout_d;
    logic                          last_wd_q, last_wd_d;
    logic                          ovfl_q, ovfl_d;
    logic                          busy_q, busy_d;

    l1a_pend_fifo #(
        .DEPTH (PEND_DEPTH),
        .WIDTH ($bits(pend_entry_t))
    ) u_pend_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (L1A),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (pop_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // The event carries the post-increment count, so the first L1A after a
    // clear is number 1. A clear coinciding with L1A restarts at 1 as well.
    // The counter advances even when the queue drops the entry.
    always_comb begin
        evt_num = L1A_CNT_RST ? {{(EVT_NUM_W-1){1'b0}}, 1'b1} : (cnt_q + 24'd1);
        cnt_d   = cnt_q;
        if (L1A) begin
            cnt_d = evt_num;
        end else if (L1A_CNT_RST) begin
            cnt_d = '0;
        end
        push_entry.alct_tmb_act = ALCT_TMB_ACT;
        push_entry.cfeb_act     = CFEB_ACT;
        push_entry.evt_num      = evt_num;
        ovfl_d = ovfl_q | (L1A & fifo_full);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cur_q     <= '0;
            dout_q    <= '0;
            last_wd_q <= 1'b0;
            ovfl_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_q     <= cur_d;
            dout_q    <= dout_d;
            last_wd_q <= last_wd_d;
            ovfl_q    <= ovfl_d;
            busy_q    <= busy_d;
        end
    end

    // Leaving Idle or B5 towards B4 pops the next entry; B5 chains straight
    // into the next header so back-to-back events leave no idle cycles.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d  = ST_WR_B4;
                    fifo_pop = 1'b1;
                end
            end
            ST_WR_B4: begin
                if (!FIFO_FULL) state_d = ST_WR_L1L;
            end
            ST_WR_L1L: begin
                if (!FIFO_FULL) state_d = ST_WR_L1H;
            end
            ST_WR_L1H: begin
                if (!FIFO_FULL) state_d = ST_WR_B5;
            end
            ST_WR_B5: begin
                if (!FIFO_FULL) begin
                    if (!fifo_empty) begin
                        state_d  = ST_WR_B4;
                        fifo_pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs are built from the next state, so the word for a
    // state is already on DOUT during the cycle that state is active. A stall
    // keeps state and entry, hence DOUT, unchanged.
    // BUSY: a pop always moves the FSM out of Idle, so the next occupancy is
    // only relevant when no pop happens, where it is nonzero iff the queue is
    // already non-empty or an L1A arrives.
    always_comb begin
        cur_d     = fifo_pop ? pend_entry_t'(pop_data) : cur_q;
        dout_d    = '0;
        last_wd_d = 1'b0;
        case (state_d)
            ST_WR_B4:  dout_d = {HDR_MARK_B4, 6'b0, cur_d.alct_tmb_act, cur_d.cfeb_act};
            ST_WR_L1L: dout_d = {4'h0, cur_d.evt_num[11:0]};
            ST_WR_L1H: dout_d = {4'h0, cur_d.evt_num[23:12]};
            ST_WR_B5: begin
                dout_d    = {HDR_MARK_B5, 8'h00};
                last_wd_d = 1'b1;
            end
            default: dout_d = '0;
        endcase
        busy_d = L1A || (fifo_count != '0) || is_wr_state(state_d);
        WR_ENA = is_wr_state(state_q) && !FIFO_FULL;
    end

    assign DOUT    = dout_q;
    assign LAST_WD = last_wd_q;
    assign PEND    = fifo_count;
    assign OVFL    = ovfl_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_l1a_hdr_writer.sv
// tb_l1a_hdr_writer
// Directed bench for l1a_hdr_writer. Stimulus pushes the header words it
// expects into a queue; a monitor on the falling edge pops and compares every
// word the DUT writes. Point checks cover reset, timing, stalls and flags.
module tb_l1a_hdr_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        l1a = 1'b0;
    logic        l1a_cnt_rst = 1'b0;
    logic        alct = 1'b0;
    logic        cfeb = 1'b0;
    logic        fifo_full = 1'b0;
    logic        wr_ena;
    logic [15:0] dout;
    logic        last_wd;
    logic [3:0]  pend;
    logic        ovfl;
    logic        busy;

    typedef struct {
        logic [15:0] dout;
        logic        last;
    } exp_word_t;

    exp_word_t exp_q[$];
    exp_word_t mon_exp;
    int        vec_count  = 0;
    int        miss_count = 0;
    int        pend_peak  = 0;

    always #5 clk = ~clk;

    l1a_hdr_writer #(
        .PEND_DEPTH (8)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .L1A          (l1a),
        .L1A_CNT_RST  (l1a_cnt_rst),
        .ALCT_TMB_ACT (alct),
        .CFEB_ACT     (cfeb),
        .FIFO_FULL    (fifo_full),
        .WR_ENA       (wr_ena),
        .DOUT         (dout),
        .LAST_WD      (last_wd),
        .PEND         (pend),
        .OVFL         (ovfl),
        .BUSY         (busy)
    );

    // Monitor: every write strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (wr_ena === 1'b1) begin
            vec_count++;
            if (exp_q.size() == 0) begin
                miss_count++;
                $display("[TB] FAIL hdr_unexpected: wrote dout=%h last=%b, required no write", dout, last_wd);
            end else begin
                mon_exp = exp_q.pop_front();
                if (dout !== mon_exp.dout || last_wd !== mon_exp.last) begin
                    miss_count++;
                    $display("[TB] FAIL hdr_word: got dout=%h last=%b, required dout=%h last=%b",
                             dout, last_wd, mon_exp.dout, mon_exp.last);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic a_l1a, input logic a_cnt_rst,
                                 input logic a_alct, input logic a_cfeb);
        l1a         = a_l1a;
        l1a_cnt_rst = a_cnt_rst;
        alct        = a_alct;
        cfeb        = a_cfeb;
        tick();
        l1a         = 1'b0;
        l1a_cnt_rst = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic pushWord(input logic [15:0] w, input logic last);
        exp_word_t e;
        e.dout = w;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic expectHeader(input logic a_alct, input logic a_cfeb, input logic [23:0] num);
        pushWord({8'hB4, 6'b0, a_alct, a_cfeb}, 1'b0);
        pushWord({4'h0, num[11:0]}, 1'b0);
        pushWord({4'h0, num[23:12]}, 1'b0);
        pushWord(16'hB500, 1'b1);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain_busy", {31'b0, busy}, 32'd0);
        checkOutput("drain_words_left", exp_q.size(), 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        checkOutput("rst_wr_ena", {31'b0, wr_ena}, 32'd0);
        checkOutput("rst_dout", {16'b0, dout}, 32'd0);
        checkOutput("rst_last_wd", {31'b0, last_wd}, 32'd0);
        checkOutput("rst_pend", {28'b0, pend}, 32'd0);
        checkOutput("rst_ovfl", {31'b0, ovfl}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        tick();

        // Single event: ALCT=1, CFEB=0, number 1
        $display("[TB] single header");
        pushWord(16'hB402, 1'b0);
        pushWord(16'h0001, 1'b0);
        pushWord(16'h0000, 1'b0);
        pushWord(16'hB500, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("single_pend_after_push", {28'b0, pend}, 32'd1);
        checkOutput("single_busy_after_push", {31'b0, busy}, 32'd1);
        checkOutput("single_wr_ena_k", {31'b0, wr_ena}, 32'd0);
        tick();
        checkOutput("single_wr_ena_k1", {31'b0, wr_ena}, 32'd1);
        checkOutput("single_dout_b4", {16'b0, dout}, 32'h0000_B402);
        checkOutput("single_pend_after_pop", {28'b0, pend}, 32'd0);
        waitIdle(20);
        checkOutput("single_last_wd_after", {31'b0, last_wd}, 32'd0);

        // Three back-to-back events; the first also clears the counter -> 1,2,3
        $display("[TB] back-to-back headers");
        pushWord(16'hB401, 1'b0); pushWord(16'h0001, 1'b0); pushWord(16'h0000, 1'b0); pushWord(16'hB500, 1'b1);
        pushWord(16'hB403, 1'b0); pushWord(16'h0002, 1'b0); pushWord(16'h0000, 1'b0); pushWord(16'hB500, 1'b1);
        pushWord(16'hB400, 1'b0); pushWord(16'h0003, 1'b0); pushWord(16'h0000, 1'b0); pushWord(16'hB500, 1'b1);
        pend_peak = 0;
        for (int i = 0; i < 15; i++) begin
            case (i)
                0:       applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
                1:       applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
                2:       applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
                default: applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            endcase
            if (int'(pend) > pend_peak) pend_peak = int'(pend);
            checkOutput($sformatf("b2b_wr_ena_%0d", i), {31'b0, wr_ena},
                        (i >= 1 && i <= 12) ? 32'd1 : 32'd0);
        end
        checkOutput("b2b_pend_peak", pend_peak, 32'd2);
        checkOutput("b2b_pend_end", {28'b0, pend}, 32'd0);
        checkOutput("b2b_busy_end", {31'b0, busy}, 32'd0);

        // Stall for 5 cycles while in Wr_L1L; event number 4
        $display("[TB] stalled header");
        pushWord(16'hB403, 1'b0); pushWord(16'h0004, 1'b0); pushWord(16'h0000, 1'b0); pushWord(16'hB500, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        checkOutput("stall_dout_l1l", {16'b0, dout}, 32'h0000_0004);
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("stall_wr_ena_%0d", i), {31'b0, wr_ena}, 32'd0);
            checkOutput($sformatf("stall_dout_%0d", i), {16'b0, dout}, 32'h0000_0004);
        end
        fifo_full = 1'b0;
        waitIdle(20);

        // Counter wrap: preset so the next two events are 0xFFFFFF and 0x000000
        $display("[TB] counter wrap");
        force dut.cnt_q = 24'hFFFFFE;
        tick();
        release dut.cnt_q;
        tick();
        pushWord(16'hB400, 1'b0); pushWord(16'h0FFF, 1'b0); pushWord(16'h0FFF, 1'b0); pushWord(16'hB500, 1'b1);
        pushWord(16'hB400, 1'b0); pushWord(16'h0000, 1'b0); pushWord(16'h0000, 1'b0); pushWord(16'hB500, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitIdle(30);

        // Overflow: ten events with the downstream FIFO full. Event 1 is taken
        // straight into the writer, events 2..9 fill the queue, 10 is dropped.
        $display("[TB] pending overflow");
        fifo_full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            expectHeader((i % 2) == 1, (i % 2) == 0, 24'(i + 1));
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, i == 0, (i % 2) == 1, (i % 2) == 0);
        end
        checkOutput("ovfl_pend_full", {28'b0, pend}, 32'd8);
        checkOutput("ovfl_flag_set", {31'b0, ovfl}, 32'd1);
        checkOutput("ovfl_wr_ena_stalled", {31'b0, wr_ena}, 32'd0);
        checkOutput("ovfl_dout_held", {16'b0, dout}, 32'h0000_B401);
        fifo_full = 1'b0;
        waitIdle(80);
        checkOutput("ovfl_flag_sticky", {31'b0, ovfl}, 32'd1);
        checkOutput("ovfl_pend_drained", {28'b0, pend}, 32'd0);
        pushWord(16'hB401, 1'b0); pushWord(16'h000B, 1'b0); pushWord(16'h0000, 1'b0); pushWord(16'hB500, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        waitIdle(20);
        checkOutput("ovfl_flag_still_set", {31'b0, ovfl}, 32'd1);

        // Reset during Wr_L1H of event 12: only B4 and L1L reach the FIFO
        $display("[TB] reset mid-header");
        pushWord(16'hB400, 1'b0);
        pushWord(16'h000C, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("midrst_wr_ena_before", {31'b0, wr_ena}, 32'd1);
        checkOutput("midrst_dout_l1h", {16'b0, dout}, 32'h0000_0000);
        rst = 1'b1;
        #1;
        checkOutput("midrst_wr_ena", {31'b0, wr_ena}, 32'd0);
        checkOutput("midrst_dout", {16'b0, dout}, 32'd0);
        checkOutput("midrst_last_wd", {31'b0, last_wd}, 32'd0);
        checkOutput("midrst_pend", {28'b0, pend}, 32'd0);
        checkOutput("midrst_ovfl", {31'b0, ovfl}, 32'd0);
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        pushWord(16'hB403, 1'b0); pushWord(16'h0001, 1'b0); pushWord(16'h0000, 1'b0); pushWord(16'hB500, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        waitIdle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
